uart_tx_fifo: RTL

//  Byte FIFO placed upstream of the UART transmitter serializer in the RV32I test SoC.
//  The CPU pushes bytes through a memory-mapped register port on the same bus as the UART and REGS blocks.
//  The serializer drains the FIFO over a valid/ready byte handshake.

---
 rtl/uart_tx_fifo.sv | 115 +++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// Byte FIFO between the CPU register port and the UART serializer.
// The CPU pushes bytes through address 0; the serializer drains them over a valid/ready handshake.
module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m_sel,
  input  logic [3:0]  m_addr,
  input  logic [31:0] m_data_i,
  output logic [31:0] m_data_o,
  input  logic        m_rd,
  input  logic        m_wr,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        irq_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0]         FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0]         CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [CW-1:0]         thresh_q, thresh_d;
  logic                  ovf_q, ovf_d;
  logic                  irq_en_q, irq_en_d;

  logic empty, full, wr_push, wr_ctrl, wr_thresh, push, pop, flush;
  logic unused_ok;

  // Reads have no side effects, so the read strobe and the unmapped write bits are never consumed.
  assign unused_ok = m_rd ^ (^m_data_i);

  assign empty     = (count_q == '0);
  assign full      = (count_q == FULL_CNT);
  assign wr_push   = m_sel & m_wr & (m_addr == 4'd0);
  assign wr_ctrl   = m_sel & m_wr & (m_addr == 4'd1);
  assign wr_thresh = m_sel & m_wr & (m_addr == 4'd2);
  assign push      = wr_push & ~full;
  assign pop       = ~empty & tx_ready_i;
  assign flush     = wr_ctrl & m_data_i[4];

  assign tx_valid_o = ~empty;
  assign tx_data_o  = mem_q[rd_ptr_q];
  assign irq_o      = irq_en_q & (count_q <= thresh_q);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    irq_en_d = irq_en_q;
    thresh_d = thresh_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    if (wr_push & full) ovf_d = 1'b1;
    if (wr_ctrl) begin
      if (m_data_i[2]) ovf_d = 1'b0;
      irq_en_d = m_data_i[3];
    end
    if (wr_thresh) thresh_d = m_data_i[DEPTH_LOG2:0];
    // Flush overrides any pop landing in the same cycle.
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      irq_en_q <= 1'b0;
      thresh_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      irq_en_q <= irq_en_d;
      thresh_q <= thresh_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= m_data_i[7:0];
  end

  always_comb begin
    m_data_o = '0;
    if (m_sel) begin
      case (m_addr)
        4'd0:    m_data_o = {{(32-CW){1'b0}}, count_q};
        4'd1:    m_data_o = {28'b0, irq_en_q, ovf_q, full, empty};
        4'd2:    m_data_o = {{(32-CW){1'b0}}, thresh_q};
        default: m_data_o = '0;
      endcase
    end
  end

endmodule
